// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//   Stall/flush sequencer for the 5-stage MIPS pipeline. It handles the hazards
//   that operand forwarding cannot cover:
//     - data-cache waits
//     - load-use hazards
//     - decode-stage branch operand hazards
//   It also squashes wrong-path fetches, drains the pipe on HALT and keeps
//   hazard performance counters.
//
// Ports
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   ihit, dhit      instruction / data cache completion strobes
//   dec_instr       instruction in the decode latch (op, rs, rt fields used)
//   br_taken        decode-stage branch/jump resolved taken
//   ex_rfWEN        EX-stage instruction writes the register file
//   ex_dREN         EX-stage instruction is a load
//   ex_dest         EX-stage destination register
//   mem_dREN        MEM-stage load
//   mem_dWEN        MEM-stage store
//   mem_dest        MEM-stage destination register
//   wb_halt         HALT has reached WB
//   pc_en           PC update enable
//   fd_en .. mw_en  pipeline latch enables
//   fd_flush        load a bubble into the fetch/decode latch (beats enable)
//   de_flush        load a bubble into the decode/EX latch (beats enable)
//   halt            sticky halted flag (registered)
//   stall_cnt       performance counter: stall cycles (wraps)
//   flush_cnt       performance counter: taken-branch flushes (wraps)
//   dwait_cnt       performance counter: data-cache wait cycles (wraps)
//
// Handshake: there is no valid/ready pair here. A latch captures on a cycle
// where its enable is 1. It loads a NOP on a cycle where its flush is 1,
// whatever its enable is.
module pipeline_hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [31:0]      dec_instr,
    input  logic             br_taken,
    input  logic             ex_rfWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_dest,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic [4:0]       mem_dest,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] dwait_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SC    = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t state;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_branch;
    logic       is_halt;
    logic       p_dwait;
    logic       p_load_use;
    logic       p_br_op;
    logic       p_fmiss;
    logic       p_taken;
    logic       unused_bits;

    assign op = dec_instr[31:26];
    assign rs = dec_instr[25:21];
    assign rt = dec_instr[20:16];

    // The immediate/rd/shamt/funct bits play no part in hazard detection.
    assign unused_bits = ^dec_instr[15:0];

    assign uses_rs   = !(op == OP_J || op == OP_JAL || op == OP_LUI || op == OP_HALT);
    assign uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                       (op == OP_SW) || (op == OP_SC);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_halt   = (op == OP_HALT);

    assign p_dwait    = (mem_dREN | mem_dWEN) & !dhit;
    assign p_load_use = ex_dREN && (ex_dest != 5'd0) &&
                        ((uses_rs && ex_dest == rs) || (uses_rt && ex_dest == rt));
    // The branch comparator only sees the MEM ALU result. So the branch must
    // wait out any ALU result still in EX and any load data still in MEM.
    assign p_br_op    = is_branch &&
                        ((ex_rfWEN && ex_dest != 5'd0 && (ex_dest == rs || ex_dest == rt)) ||
                         (mem_dREN && mem_dest != 5'd0 && (mem_dest == rs || mem_dest == rt)));
    assign p_fmiss    = !ihit;
    assign p_taken    = br_taken & ihit;

    always_comb begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        if (!RST) begin
            case (state)
                RUN: begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                    de_en = 1'b1;
                    em_en = 1'b1;
                    mw_en = 1'b1;
                    if (p_dwait) begin
                        pc_en = 1'b0;
                        fd_en = 1'b0;
                        de_en = 1'b0;
                        em_en = 1'b0;
                        mw_en = 1'b0;
                    end else if (p_load_use || p_br_op) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end else if (p_fmiss) begin
                        pc_en    = 1'b0;
                        fd_flush = 1'b1;
                    end else if (p_taken) begin
                        fd_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    // Nothing new is fetched. Older instructions retire
                    // unless the data cache is holding MEM.
                    fd_flush = 1'b1;
                    if (!p_dwait) begin
                        fd_en = 1'b1;
                        de_en = 1'b1;
                        em_en = 1'b1;
                        mw_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halt      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            dwait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (p_dwait)
                        dwait_cnt <= dwait_cnt + CNT_W'(1);
                    else if (p_load_use || p_br_op || p_fmiss)
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    else if (p_taken)
                        flush_cnt <= flush_cnt + CNT_W'(1);

                    if (wb_halt) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (is_halt && !(p_dwait || p_load_use || p_br_op)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (p_dwait)
                        dwait_cnt <= dwait_cnt + CNT_W'(1);
                    if (wb_halt) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
//   Self-checking bench for pipeline_hazard_controller. A table of
//   single-cycle RUN-state vectors comes first. Hand-written sequences follow
//   for the multi-cycle cases:
//     - load then branch
//     - data-cache wait
//     - HALT drain
//     - reset during drain
//   Inputs change on the falling edge. The combinational outputs are checked
//   1 time unit later. The counters are checked 1 time unit after the rising
//   edge.
module tb_pipeline_hazard_controller;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LUI  = 6'd15;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_SC   = 6'd56;
    localparam logic [5:0] OP_HALT = 6'd63;

    // Output bit order: {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halt}
    localparam logic [7:0] O_DEF    = 8'b11111000;
    localparam logic [7:0] O_STALL  = 8'b00111010;
    localparam logic [7:0] O_MISS   = 8'b01111100;
    localparam logic [7:0] O_BR     = 8'b11111100;
    localparam logic [7:0] O_FRZ    = 8'b00000000;
    localparam logic [7:0] O_DRAIN  = 8'b00111100;
    localparam logic [7:0] O_HALTED = 8'b00000001;
    localparam logic [7:0] M_ALL    = 8'b11111111;
    localparam logic [7:0] M_DRAIN  = 8'b10111111;

    typedef struct {
        logic        rst;
        logic        wbh;
        logic        ihit;
        logic        dhit;
        logic [31:0] ins;
        logic        br;
        logic        ex_rf;
        logic        ex_ld;
        logic [4:0]  ex_dest;
        logic        m_ld;
        logic        m_st;
        logic [4:0]  m_dest;
        logic [7:0]  exp;
        logic [31:0] ds;
        logic [31:0] df;
        logic [31:0] dw;
    } vec_t;

    logic             CLK;
    logic             RST;
    logic             ihit;
    logic             dhit;
    logic [31:0]      dec_instr;
    logic             br_taken;
    logic             ex_rfWEN;
    logic             ex_dREN;
    logic [4:0]       ex_dest;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic [4:0]       mem_dest;
    logic             wb_halt;
    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] dwait_cnt;

    logic [7:0]  exp_q[$];
    logic [31:0] es;
    logic [31:0] ef;
    logic [31:0] ew;
    int          n_cmp;
    int          n_fail;
    vec_t        tbl[$];

    pipeline_hazard_controller #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ihit      (ihit),
        .dhit      (dhit),
        .dec_instr (dec_instr),
        .br_taken  (br_taken),
        .ex_rfWEN  (ex_rfWEN),
        .ex_dREN   (ex_dREN),
        .ex_dest   (ex_dest),
        .mem_dREN  (mem_dREN),
        .mem_dWEN  (mem_dWEN),
        .mem_dest  (mem_dest),
        .wb_halt   (wb_halt),
        .pc_en     (pc_en),
        .fd_en     (fd_en),
        .de_en     (de_en),
        .em_en     (em_en),
        .mw_en     (mw_en),
        .fd_flush  (fd_flush),
        .de_flush  (de_flush),
        .halt      (halt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .dwait_cnt (dwait_cnt)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic ih, input logic dh,
                                input logic br, input logic exrf, input logic exld,
                                input logic [4:0] exd, input logic mld, input logic mst,
                                input logic [4:0] md, input logic [7:0] e,
                                input logic [31:0] ds, input logic [31:0] df,
                                input logic [31:0] dw);
        vec_t v;
        v.rst = 1'b0;  v.wbh = 1'b0;  v.ihit = ih;   v.dhit = dh;
        v.ins = i;     v.br = br;     v.ex_rf = exrf; v.ex_ld = exld;
        v.ex_dest = exd; v.m_ld = mld; v.m_st = mst;  v.m_dest = md;
        v.exp = e;     v.ds = ds;     v.df = df;     v.dw = dw;
        return v;
    endfunction

    // A clean cycle: NOP in decode, nothing outstanding, both caches hitting.
    function automatic vec_t clean(input logic [7:0] e);
        return mk(32'h0, 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, e, 0, 0, 0);
    endfunction

    // Driver + scoreboard: drive one cycle, check outputs, then check counters.
    task automatic apply(input vec_t v, input logic [7:0] mask, input string tag);
        logic [7:0] e;
        logic [7:0] got;
        @(negedge CLK);
        RST = v.rst;  wb_halt = v.wbh;  ihit = v.ihit;  dhit = v.dhit;
        dec_instr = v.ins;  br_taken = v.br;  ex_rfWEN = v.ex_rf;  ex_dREN = v.ex_ld;
        ex_dest = v.ex_dest;  mem_dREN = v.m_ld;  mem_dWEN = v.m_st;  mem_dest = v.m_dest;
        exp_q.push_back(v.exp);
        #1;
        got = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, halt};
        e = exp_q.pop_front();
        n_cmp++;
        if ((got & mask) !== (e & mask)) begin
            n_fail++;
            $display("FAIL %s outputs: got %b expected %b (mask %b)", tag, got, e, mask);
        end
        @(posedge CLK);
        #1;
        if (v.rst) begin
            es = 0; ef = 0; ew = 0;
        end else begin
            es = es + v.ds; ef = ef + v.df; ew = ew + v.dw;
        end
        n_cmp++;
        if ({stall_cnt, flush_cnt, dwait_cnt} !== {es, ef, ew}) begin
            n_fail++;
            $display("FAIL %s counters: got stall=%0d flush=%0d dwait=%0d expected %0d/%0d/%0d",
                     tag, stall_cnt, flush_cnt, dwait_cnt, es, ef, ew);
        end
    endtask

    task automatic do_reset(input logic [7:0] e, input string tag);
        vec_t v;
        v = clean(e);
        v.rst = 1'b1;
        apply(v, M_ALL, tag);
    endtask

    initial begin
        vec_t v;
        int   r;
        int   q;
        n_cmp = 0; n_fail = 0; es = 0; ef = 0; ew = 0;

        // Single-cycle RUN-state vectors:
        //   ins, ihit, dhit, br, ex_rf, ex_ld, ex_dest, m_ld, m_st, m_dest, exp, ds, df, dw
        tbl.push_back(mk(32'h0,                   1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_DEF,   0, 0, 0));
        tbl.push_back(mk(ins(OP_R, 5'd2, 5'd4),   1, 1, 0, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_R, 5'd4, 5'd2),   1, 1, 0, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_R, 5'd0, 5'd3),   1, 1, 0, 1, 1, 5'd0, 0, 0, 5'd0, O_DEF,   0, 0, 0));
        tbl.push_back(mk(ins(OP_ADDI, 5'd1, 5'd7), 1, 1, 0, 1, 1, 5'd7, 0, 0, 5'd0, O_DEF,  0, 0, 0));
        tbl.push_back(mk(ins(OP_LUI, 5'd5, 5'd6), 1, 1, 0, 1, 1, 5'd5, 0, 0, 5'd0, O_DEF,   0, 0, 0));
        tbl.push_back(mk(ins(OP_SW, 5'd1, 5'd9),  1, 1, 0, 1, 1, 5'd9, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_BEQ, 5'd6, 5'd7), 1, 1, 0, 1, 0, 5'd6, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_BNE, 5'd1, 5'd8), 1, 1, 0, 0, 0, 5'd0, 1, 0, 5'd8, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_BEQ, 5'd1, 5'd8), 1, 1, 0, 0, 0, 5'd0, 0, 1, 5'd8, O_DEF,   0, 0, 0));
        tbl.push_back(mk(ins(OP_R, 5'd2, 5'd4),   1, 1, 0, 1, 0, 5'd2, 0, 0, 5'd0, O_DEF,   0, 0, 0));
        tbl.push_back(mk(32'h0,                   1, 0, 0, 0, 0, 5'd0, 0, 1, 5'd0, O_FRZ,   0, 0, 1));
        tbl.push_back(mk(ins(OP_R, 5'd2, 5'd4),   1, 0, 1, 1, 1, 5'd2, 1, 0, 5'd3, O_FRZ,   0, 0, 1));
        tbl.push_back(mk(32'h0,                   0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_MISS,  1, 0, 0));
        tbl.push_back(mk(32'h0,                   0, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, O_MISS,  1, 0, 0));
        tbl.push_back(mk(ins(OP_R, 5'd2, 5'd4),   0, 1, 0, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(32'h0,                   1, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, O_BR,    0, 1, 0));
        tbl.push_back(mk(ins(OP_R, 5'd2, 5'd4),   1, 1, 1, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0));
        tbl.push_back(mk(ins(OP_J, 5'd3, 5'd3),   1, 1, 0, 1, 1, 5'd3, 0, 0, 5'd0, O_DEF,   0, 0, 0));
        tbl.push_back(mk(ins(OP_SC, 5'd1, 5'd11), 1, 1, 0, 1, 1, 5'd11, 0, 0, 5'd0, O_STALL, 1, 0, 0));

        do_reset(O_FRZ, "reset");
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], M_ALL, $sformatf("vec%0d", i));

        // Random registers: a load-use on rt stalls; a different register does not.
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(1, 31);
            q = (r % 31) + 1;
            apply(mk(ins(OP_R, 5'(q), 5'(r)), 1, 1, 0, 1, 1, 5'(r), 0, 0, 5'd0, O_STALL, 1, 0, 0),
                  M_ALL, "rand_hit");
            apply(mk(ins(OP_R, 5'(q), 5'(q)), 1, 1, 0, 1, 1, 5'(r), 0, 0, 5'd0, O_DEF, 0, 0, 0),
                  M_ALL, "rand_miss");
        end

        // LW $2 ; ADD $3,$2,$4
        apply(mk(ins(OP_LW, 5'd1, 5'd2), 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_DEF, 0, 0, 0), M_ALL, "lu_lw");
        apply(mk(ins(OP_R, 5'd2, 5'd4), 1, 1, 0, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0), M_ALL, "lu_stall");
        apply(mk(ins(OP_R, 5'd2, 5'd4), 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_DEF, 0, 0, 0), M_ALL, "lu_go");

        // LW $5 ; BEQ $5,$6 -> P2, P3, then the branch resolves taken
        apply(mk(ins(OP_BEQ, 5'd5, 5'd6), 1, 1, 0, 1, 1, 5'd5, 0, 0, 5'd0, O_STALL, 1, 0, 0), M_ALL, "lb_p2");
        apply(mk(ins(OP_BEQ, 5'd5, 5'd6), 1, 1, 1, 0, 0, 5'd0, 1, 0, 5'd5, O_STALL, 1, 0, 0), M_ALL, "lb_p3");
        apply(mk(ins(OP_BEQ, 5'd5, 5'd6), 1, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, O_BR, 0, 1, 0), M_ALL, "lb_take");

        // SW in MEM, dhit low for 4 cycles
        for (int i = 0; i < 4; i++)
            apply(mk(32'h0, 1, 0, 0, 0, 0, 5'd0, 0, 1, 5'd0, O_FRZ, 0, 0, 1), M_ALL, "dwait");
        apply(mk(32'h0, 1, 1, 0, 0, 0, 5'd0, 0, 1, 5'd0, O_DEF, 0, 0, 0), M_ALL, "dwait_done");

        // Taken branch with a simultaneous data miss: only the freeze applies
        apply(mk(32'h0, 1, 0, 1, 0, 0, 5'd0, 1, 0, 5'd4, O_FRZ, 0, 0, 1), M_ALL, "br_dmiss");

        // HALT blocked by a data wait stays in RUN
        apply(mk(ins(OP_HALT, 5'd0, 5'd0), 1, 0, 0, 0, 0, 5'd0, 0, 1, 5'd0, O_FRZ, 0, 0, 1), M_ALL, "halt_blk");
        apply(clean(O_DEF), M_ALL, "halt_blk_run");

        // HALT drain: wb_halt 3 cycles after decode, then halted and frozen
        apply(mk(ins(OP_HALT, 5'd0, 5'd0), 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_DEF, 0, 0, 0), M_ALL, "halt_dec");
        apply(clean(O_DRAIN), M_DRAIN, "drain1");
        apply(clean(O_DRAIN), M_DRAIN, "drain2");
        v = clean(O_DRAIN); v.wbh = 1'b1;
        apply(v, M_DRAIN, "drain_wb");
        apply(mk(32'h0, 0, 0, 1, 0, 0, 5'd0, 1, 0, 5'd2, O_HALTED, 0, 0, 0), M_ALL, "halted1");
        apply(mk(ins(OP_R, 5'd2, 5'd4), 1, 1, 1, 1, 1, 5'd2, 0, 0, 5'd0, O_HALTED, 0, 0, 0), M_ALL, "halted2");
        do_reset(O_HALTED, "rst_halted");
        apply(clean(O_DEF), M_ALL, "post_rst1");

        // wb_halt seen in RUN goes straight to HALTED
        v = clean(O_DEF); v.wbh = 1'b1;
        apply(v, M_ALL, "run_wb");
        apply(clean(O_HALTED), M_ALL, "run_wb_halted");
        do_reset(O_HALTED, "rst2");

        // Reset in the middle of a drain
        apply(mk(ins(OP_R, 5'd2, 5'd4), 1, 1, 0, 1, 1, 5'd2, 0, 0, 5'd0, O_STALL, 1, 0, 0), M_ALL, "pre_drain");
        apply(mk(ins(OP_HALT, 5'd0, 5'd0), 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, O_DEF, 0, 0, 0), M_ALL, "halt_dec2");
        apply(clean(O_DRAIN), M_DRAIN, "drain3");
        do_reset(O_FRZ, "rst_drain");
        apply(clean(O_DEF), M_ALL, "post_rst2");

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
